mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mau_pkg.sv | 24 ++
 rtl/mau_timer.sv | 32 +++
 rtl/mem_access_unit.sv | 109 ++++++++++
 tb/tb_mem_access_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared types and constants for the memory access unit.
package mau_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    ERR
  } state_t;

  typedef enum logic [1:0] {
    ACC_FETCH,
    ACC_LOAD,
    ACC_STORE
  } acc_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_CONFLICT = 2'b11;

  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mau_timer.sv
// Bus wait counter: cleared at access launch, counts BUSY cycles, flags the last allowed one.
module mau_timer
  import mau_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  // High during the TIMEOUT-th BUSY cycle, so the access gives up on that cycle's edge.
  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle-CPU memory front end: launches fetch/load/store bus accesses and stalls the controller.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lord,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] writedata,
  input  logic              irwrite,
  input  logic              memread,
  input  logic              memwrite,
  output logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] data,
  output logic [5:0]        op,
  output logic [5:0]        funct,
  output logic [1:0]        err,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  acc_t              kind;
  logic              cmd;
  logic              conflict;
  logic              misaligned;
  logic              expired;
  logic [DATA_W-1:0] addr;

  assign cmd        = irwrite | memread | memwrite;
  assign conflict   = memwrite & (irwrite | memread);
  assign addr       = lord ? aluout : pc;
  assign misaligned = (addr[1:0] != 2'b00);

  assign stall = (cmd && state == IDLE) || state == BUSY || state == ERR;
  assign op    = instr[31:26];
  assign funct = instr[5:0];

  mau_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == IDLE),
    .enable  (state == BUSY),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      kind      <= ACC_FETCH;
      instr     <= '0;
      data      <= '0;
      err       <= ERR_NONE;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd) begin
            // Conflict outranks misalignment; neither ever reaches the bus.
            if (conflict) begin
              err   <= ERR_CONFLICT;
              state <= ERR;
            end else if (misaligned) begin
              err   <= ERR_MISALIGN;
              state <= ERR;
            end else begin
              mem_addr  <= addr;
              mem_we    <= memwrite;
              mem_wdata <= writedata;
              kind      <= memwrite ? ACC_STORE : (irwrite ? ACC_FETCH : ACC_LOAD);
              mem_valid <= 1'b1;
              state     <= BUSY;
            end
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (kind == ACC_FETCH) instr <= mem_rdata;
            if (kind == ACC_LOAD)  data  <= mem_rdata;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            state     <= DONE;
          end else if (expired) begin
            err       <= ERR_TIMEOUT;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            state     <= ERR;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= ERR;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: fetch, waited load, store, errors, timeout and async reset.
module tb_mem_access_unit;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              lord;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] aluout;
  logic [DATA_W-1:0] writedata;
  logic              irwrite;
  logic              memread;
  logic              memwrite;
  logic              stall;
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] data;
  logic [5:0]        op;
  logic [5:0]        funct;
  logic [1:0]        err;
  logic              mem_valid;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.DATA_W(DATA_W), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .lord      (lord),
    .pc        (pc),
    .aluout    (aluout),
    .writedata (writedata),
    .irwrite   (irwrite),
    .memread   (memread),
    .memwrite  (memwrite),
    .stall     (stall),
    .instr     (instr),
    .data      (data),
    .op        (op),
    .funct     (funct),
    .err       (err),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".stall"},     32'(stall),     32'h0);
    check({tag, ".instr"},     instr,          32'h0);
    check({tag, ".data"},      data,           32'h0);
    check({tag, ".err"},       32'(err),       32'h0);
    check({tag, ".mem_valid"}, 32'(mem_valid), 32'h0);
    check({tag, ".mem_we"},    32'(mem_we),    32'h0);
    check({tag, ".mem_addr"},  mem_addr,       32'h0);
    check({tag, ".mem_wdata"}, mem_wdata,      32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; lord = 1'b0; pc = '0; aluout = '0; writedata = '0;
    irwrite = 1'b0; memread = 1'b0; memwrite = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    #2;
    check_cleared("reset");
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Fetch, zero-wait bus
    lord = 1'b0; pc = 32'h40; irwrite = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h012A4020;
    #1;
    check("fetch.idle_stall", 32'(stall), 32'h1);
    check("fetch.idle_valid", 32'(mem_valid), 32'h0);
    tick();
    irwrite = 1'b0;
    check("fetch.busy_valid", 32'(mem_valid), 32'h1);
    check("fetch.busy_addr",  mem_addr, 32'h40);
    check("fetch.busy_we",    32'(mem_we), 32'h0);
    check("fetch.busy_stall", 32'(stall), 32'h1);
    tick();
    check("fetch.done_stall", 32'(stall), 32'h0);
    check("fetch.done_valid", 32'(mem_valid), 32'h0);
    check("fetch.instr",      instr, 32'h012A4020);
    check("fetch.op",         32'(op), 32'h0);
    check("fetch.funct",      32'(funct), 32'h20);
    mem_ready = 1'b0;
    tick();
    check("fetch.idle_after", 32'(stall), 32'h0);

    // Load with three wait states
    lord = 1'b1; aluout = 32'h100; memread = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    memread = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("load.valid%0d", i), 32'(mem_valid), 32'h1);
      check($sformatf("load.addr%0d", i),  mem_addr, 32'h100);
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    check("load.done_valid", 32'(mem_valid), 32'h0);
    check("load.done_stall", 32'(stall), 32'h0);
    check("load.data",       data, 32'hCAFEF00D);
    check("load.instr_kept", instr, 32'h012A4020);
    mem_ready = 1'b0;
    tick();

    // Store
    lord = 1'b1; aluout = 32'h8; writedata = 32'hDEADBEEF; memwrite = 1'b1;
    mem_ready = 1'b1; mem_rdata = 32'h11111111;
    tick();
    memwrite = 1'b0;
    check("store.valid", 32'(mem_valid), 32'h1);
    check("store.we",    32'(mem_we), 32'h1);
    check("store.wdata", mem_wdata, 32'hDEADBEEF);
    check("store.addr",  mem_addr, 32'h8);
    tick();
    check("store.instr_kept", instr, 32'h012A4020);
    check("store.data_kept",  data, 32'hCAFEF00D);
    check("store.done_stall", 32'(stall), 32'h0);
    mem_ready = 1'b0;
    tick();

    // Fetch and load together behave as a fetch
    lord = 1'b0; pc = 32'h44; irwrite = 1'b1; memread = 1'b1;
    mem_ready = 1'b1; mem_rdata = 32'hFC000003;
    tick();
    irwrite = 1'b0; memread = 1'b0;
    tick();
    check("dual.instr",     instr, 32'hFC000003);
    check("dual.op",        32'(op), 32'h3F);
    check("dual.funct",     32'(funct), 32'h03);
    check("dual.data_kept", data, 32'hCAFEF00D);
    mem_ready = 1'b0;
    tick();

    // Timeout
    lord = 1'b1; aluout = 32'h200; memread = 1'b1;
    tick();
    memread = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("timeout.valid%0d", i), 32'(mem_valid), 32'h1);
      tick();
    end
    check("timeout.err",   32'(err), 32'h2);
    check("timeout.valid", 32'(mem_valid), 32'h0);
    check("timeout.stall", 32'(stall), 32'h1);
    mem_ready = 1'b1;
    tick();
    check("timeout.held_err",   32'(err), 32'h2);
    check("timeout.held_stall", 32'(stall), 32'h1);
    mem_ready = 1'b0;
    do_reset();

    // Misaligned load
    lord = 1'b1; aluout = 32'h102; memread = 1'b1;
    tick();
    memread = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("misalign.valid%0d", i), 32'(mem_valid), 32'h0);
      check($sformatf("misalign.stall%0d", i), 32'(stall), 32'h1);
      tick();
    end
    check("misalign.err", 32'(err), 32'h1);
    do_reset();

    // Conflicting command
    lord = 1'b1; aluout = 32'h10; memwrite = 1'b1; irwrite = 1'b1;
    tick();
    memwrite = 1'b0; irwrite = 1'b0;
    check("conflict.err",   32'(err), 32'h3);
    check("conflict.valid", 32'(mem_valid), 32'h0);
    check("conflict.we",    32'(mem_we), 32'h0);
    check("conflict.addr",  mem_addr, 32'h0);
    check("conflict.stall", 32'(stall), 32'h1);
    do_reset();

    // Reset mid-BUSY: fill registers first so the clear is observable
    lord = 1'b0; pc = 32'h80; irwrite = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h12345678;
    tick();
    irwrite = 1'b0;
    tick();
    check("prefill.instr", instr, 32'h12345678);
    mem_ready = 1'b0;
    tick();
    lord = 1'b1; aluout = 32'h300; writedata = 32'h55AA55AA; memread = 1'b1;
    tick();
    memread = 1'b0;
    tick();
    check("midbusy.valid", 32'(mem_valid), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check_cleared("midbusy");
    mem_ready = 1'b1; mem_rdata = 32'hA5A5A5A5;
    tick();
    check("midbusy.instr_after", instr, 32'h0);
    check("midbusy.data_after",  data, 32'h0);
    check("midbusy.valid_after", 32'(mem_valid), 32'h0);
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
